// File: rtl/md_iter_ctrl.sv
// md_iter_ctrl: iterative shift-add multiply / restoring divide sequencer with RISC-V sign rules
module md_iter_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       op_i,
  input  logic [1:0]       signed_mode_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             kill_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIN = 2'd2, DONE = 2'd3;
  localparam logic [1:0] MULL = 2'd0, MULH = 2'd1, DIV = 2'd2;
  logic [1:0]         state, op;
  logic               neg_a, neg_b;
  logic [WIDTH-1:0]   mag_a, mag_b, result;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     rem;
  logic [CW-1:0]      cnt;
  logic               accept, div_zero, in_sa, in_sb;
  logic [WIDTH-1:0]   abs_a, abs_b, quot, fin_res;
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] mul_next, prod;
  logic [WIDTH+1:0]   sh, diff;
  assign ready_o  = state == IDLE;
  assign busy_o   = state != IDLE;
  assign valid_o  = state == DONE;
  assign result_o = result;
  // operand conditioning, one iteration step of each algorithm, and final sign correction
  always_comb begin
    accept   = valid_i & ready_o & ~kill_i;
    div_zero = op_i[1] & (op_b_i == '0);
    in_sa    = signed_mode_i[0] & op_a_i[WIDTH-1];
    in_sb    = (op_i[1] ? signed_mode_i[0] : signed_mode_i[1]) & op_b_i[WIDTH-1];
    abs_a    = in_sa ? -op_a_i : op_a_i;
    abs_b    = in_sb ? -op_b_i : op_b_i;
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
    mul_next = {add_sum, acc[WIDTH-1:1]};
    sh       = {rem, acc[WIDTH-1]};
    diff     = sh - {2'b00, mag_b};
    quot     = acc[WIDTH-1:0];
    prod     = (neg_a ^ neg_b) ? -acc : acc;
    fin_res  = op == MULL ? prod[WIDTH-1:0] :
               op == MULH ? prod[2*WIDTH-1:WIDTH] :
               op == DIV  ? ((neg_a ^ neg_b) ? -quot : quot) :
               (neg_a ? -rem[WIDTH-1:0] : rem[WIDTH-1:0]);
  end
  // control: state sequencing, iteration counter and result register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      result <= '0;
    end else if (kill_i) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          state <= div_zero ? DONE : CALC;
          cnt   <= '0;
          if (div_zero) result <= op_i[0] ? op_a_i : '1;
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIN;
        end
        FIN: begin
          result <= fin_res;
          state  <= DONE;
        end
        default: if (ready_i) state <= IDLE;
      endcase
    end
  end
  // datapath: latch operand magnitudes on accept, then iterate while in CALC
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op    <= MULL;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      mag_a <= '0;
      mag_b <= '0;
      acc   <= '0;
      rem   <= '0;
    end else if (accept) begin
      op    <= op_i;
      neg_a <= in_sa;
      neg_b <= in_sb;
      mag_a <= abs_a;
      mag_b <= abs_b;
      acc   <= {{WIDTH{1'b0}}, op_i[1] ? abs_a : abs_b};
      rem   <= '0;
    end else if (state == CALC) begin
      acc <= op[1] ? {{WIDTH{1'b0}}, acc[WIDTH-2:0], ~diff[WIDTH+1]} : mul_next;
      rem <= op[1] ? (diff[WIDTH+1] ? sh[WIDTH:0] : diff[WIDTH:0]) : rem;
    end
  end
endmodule

// File: doc/md_iter_ctrl.md
Name: md_iter_ctrl

Overview:
Iterative multiply/divide sequencer for the EX stage. It accepts one md_op_e operation (MD_OP_MULL, MD_OP_MULH, MD_OP_DIV, MD_OP_REM) through a valid/ready handshake. It runs a radix-2 shift-add multiply or a restoring divide on operand magnitudes, applies the RISC-V sign and special-case rules, and holds the 32-bit result until the consumer accepts it. The ALU issues to it when the decoder selects the M extension, and the controller can abort it through kill_i.

Parameters:
- WIDTH, 32, operand and result width; the iteration count equals WIDTH.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset, synchronous, active-high
- valid_i  input  1  operation request
- ready_o  output  1  unit can accept a request; high only in IDLE
- op_i  input  2  md_op_e: 0 MULL, 1 MULH, 2 DIV, 3 REM
- signed_mode_i  input  2  bit0: operand a signed; bit1: operand b signed. For DIV/REM, bit0 governs both operands.
- op_a_i  input  WIDTH  multiplicand or dividend
- op_b_i  input  WIDTH  multiplier or divisor
- kill_i  input  1  abort the in-flight operation
- valid_o  output  1  result available
- ready_i  input  1  consumer accepts the result
- result_o  output  WIDTH  result
- busy_o  output  1  state is not IDLE

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous, active-high.
- Reset values: state=IDLE, valid_o=0, result_o=0, busy_o=0, ready_o=1, counter=0.
- States: IDLE, CALC, FIN, DONE.
- IDLE:
  - Accept when valid_i & ready_o at edge E0. Latch op, signedness, sign_a, sign_b, |a| and |b|.
  - The magnitude of a signed operand is its two's-complement negation when its MSB is set. 0x80000000 maps to 0x80000000 unsigned.
  - If op is DIV/REM and op_b_i==0, go to DONE with the special result. valid_o rises after E0+1.
  - Otherwise go to CALC with counter=0.
- CALC, multiply: each cycle, if multiplier LSB is set, add multiplicand into the upper half of the 2*WIDTH accumulator. Then shift the accumulator right 1.
- CALC, divide: each cycle, shift the {rem, quot} pair left 1 and trial-subtract |b|. If the result is non-negative, keep it and set the quotient LSB.
- CALC exit: the counter increments each cycle. After WIDTH cycles (counter==WIDTH-1 at the edge), go to FIN.
- FIN, one cycle, sets result then goes to DONE:
  - MULL: low WIDTH bits of the signed-corrected product.
  - MULH: high WIDTH bits of the signed-corrected product. The product is negated when sign_a^sign_b.
  - DIV: quotient, negated when sign_a^sign_b.
  - REM: remainder, negated when sign_a (sign follows the dividend).
- Latency: valid_o asserted after edge E0+WIDTH+2, i.e. 34 edges counting E0 for WIDTH=32.
- Special cases:
  - Divide by zero: DIV yields all ones, signed or unsigned. REM yields op_a_i unchanged.
  - Signed overflow, 0x80000000 / 0xFFFFFFFF: DIV gives 0x80000000, REM gives 0. No special path is needed; the normal algorithm must produce these values.
- DONE:
  - valid_o=1. result_o stays stable until valid_o & ready_i.
  - On the handshake edge go to IDLE; valid_o=0 and ready_o=1 next cycle.
  - No new request is accepted in the same cycle as a result handshake.
- kill_i:
  - In CALC, FIN or DONE: next state IDLE, valid_o=0, and the result is discarded.
  - In IDLE, kill_i has priority over valid_i: the request is not accepted.
- rst_i mid-operation: immediate return to reset values on the next edge. Reset has priority over kill_i and every handshake.
- Input handling: inputs are ignored outside IDLE, and changing op_a_i/op_b_i after acceptance has no effect.
- Arithmetic width: the accumulator is 2*WIDTH. The divider remainder register is WIDTH+1 bits so the trial subtract can borrow.

Test Plan:
- MULL, signed_mode=11, a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB. valid_o rises 34 edges after acceptance.
- MULH cases:
  - signed_mode=11, a=b=0x80000000 -> 0x40000000.
  - signed_mode=00, a=b=0xFFFFFFFF -> 0xFFFFFFFE.
  - signed_mode=01, a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV/REM signed, a=0xFFFFFFF9 (-7), b=2 -> DIV 0xFFFFFFFD, REM 0xFFFFFFFF. Unsigned DIV 100/7 -> 14, REM -> 2.
- Divide by zero and overflow:
  - DIV a=5, b=0 -> 0xFFFFFFFF, with valid_o one edge after acceptance.
  - REM a=5, b=0 -> 5.
  - Signed DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- Backpressure: hold ready_i=0 for 10 cycles after valid_o -> result_o stable and ready_o=0 throughout. Pulse ready_i -> next cycle valid_o=0, ready_o=1.
- Abort and reset:
  - kill_i at CALC cycle 10 -> IDLE next edge, no valid_o. A following MULL 3*4 returns 12.
  - rst_i during CALC -> all outputs return to their reset values.
